// File: rtl/divider_pkg.sv
// Shared types and constants for the programmable clock divider.
package divider_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } div_state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/divider_core.sv
// Counter/compare datapath: holds the active divisor and counts 0..cur_div-1.
module divider_core #(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cur_div,
    output logic             wrap
);

    assign wrap = run && (cnt == cur_div - WIDTH'(1));

    // A load always lands on the same edge the counter restarts, so a
    // new divisor only ever takes effect from a fresh period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            cur_div <= WIDTH'(DEFAULT_DIV);
        end else begin
            if (load)
                cur_div <= div;
            if (!run || wrap)
                cnt <= '0;
            else
                cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/divider_ctrl.sv
// Divider controller: run/stop FSM, divisor handshake and pending register.
module divider_ctrl
    import divider_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clkout,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             err
);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] cnt;
    logic             wrap;
    logic             run;
    logic             xfer;
    logic             legal;
    logic             load;
    logic [WIDTH-1:0] load_div;
    logic             pend_take;

    assign run       = (state != STOP);
    assign div_ready = (state != PEND);
    assign xfer      = div_valid && div_ready;
    assign legal     = (div_in >= WIDTH'(MIN_DIV));

    divider_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .load    (load),
        .div     (load_div),
        .cnt     (cnt),
        .cur_div (cur_div),
        .wrap    (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= STOP;
        else
            state <= state_nxt;
    end

    // en is only consulted at the period boundary, so dropping and
    // re-raising it mid-period never cuts a phase short.
    always_comb begin
        state_nxt = state;
        unique case (state)
            STOP: if (en) state_nxt = RUN;
            RUN: begin
                if (wrap && !en)
                    state_nxt = STOP;
                else if (xfer && legal && !wrap)
                    state_nxt = PEND;
            end
            PEND: if (wrap) state_nxt = en ? RUN : STOP;
            default: state_nxt = STOP;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_div  = div_in;
        pend_take = 1'b0;
        unique case (state)
            STOP: load = xfer && legal;
            RUN: begin
                load      = xfer && legal && wrap;
                pend_take = xfer && legal && !wrap;
            end
            PEND: begin
                load     = wrap;
                load_div = pend_div;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_div <= '0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (pend_take)
                pend_div <= div_in;
            clkout <= run && (cnt < (cur_div >> 1));
            tick   <= wrap;
            err    <= xfer && !legal;
        end
    end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: directed table, corner sequences, random run vs. model.
module tb_divider_ctrl;

    localparam int W  = 8;
    localparam int DD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         div_valid = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_ready, clkout, tick, err;
    logic [W-1:0] cur_div;

    divider_ctrl #(.WIDTH(W), .DEFAULT_DIV(DD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clkout    (clkout),
        .tick      (tick),
        .cur_div   (cur_div),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current period, active divisor,
    // a queue of accepted-but-not-yet-applied divisors, and a running flag.
    bit m_run;
    int m_pos;
    int m_div;
    int m_pend[$];
    bit e_clk, e_tick, e_err, e_rdy;

    typedef struct {
        bit         r, e, v;
        logic [7:0] d;
        bit         ck, tk, er, rd;
        logic [7:0] cd;
    } vec_t;

    task automatic check(input string nm, input logic [W+3:0] act, input logic [W+3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got {clk,tick,err,rdy,div}=%b_%0d want %b_%0d",
                     nm, $time, act[W+3:W], act[W-1:0], exp[W+3:W], exp[W-1:0]);
        end
    endtask

    function automatic void model_step(bit r, bit e, bit v, int d);
        bit x, bnd;
        if (!r) begin
            m_run = 0; m_pos = 0; m_div = DD; m_pend.delete();
            e_clk = 0; e_tick = 0; e_err = 0; e_rdy = 1;
            return;
        end
        x      = v && (m_pend.size() == 0);
        bnd    = m_run && (m_pos == m_div - 1);
        e_tick = bnd;
        e_clk  = m_run && (m_pos < m_div / 2);
        e_err  = x && (d < 2);
        if (x && d >= 2 && m_run && !bnd)
            m_pend.push_back(d);
        if (!m_run) begin
            if (x && d >= 2) m_div = d;
            m_run = e;
            m_pos = 0;
        end else if (bnd) begin
            if (m_pend.size() > 0) m_div = m_pend.pop_front();
            else if (x && d >= 2) m_div = d;
            m_pos = 0;
            m_run = e;
        end else begin
            m_pos++;
        end
        e_rdy = (m_pend.size() == 0);
    endfunction

    function automatic logic [W+3:0] dut_out();
        return {clkout, tick, err, div_ready, cur_div};
    endfunction

    task automatic drive(input bit r, input bit e, input bit v, input int d);
        rst_n = r; en = e; div_valid = v; div_in = W'(d);
        model_step(r, e, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input bit r, input bit e, input bit v, input int d);
        drive(r, e, v, d);
        check(nm, dut_out(), {e_clk, e_tick, e_err, e_rdy, W'(m_div)});
    endtask

    vec_t tbl[13];

    initial begin
        bit seen6;
        bit done;

        // Reset, run at 4 (1100), write 5 at cnt=1, then a rejected divisor of 1.
        tbl[0]  = '{0,0,0,0, 0,0,0,1,4};
        tbl[1]  = '{1,1,0,0, 0,0,0,1,4};
        tbl[2]  = '{1,1,0,0, 1,0,0,1,4};
        tbl[3]  = '{1,1,1,5, 1,0,0,0,4};
        tbl[4]  = '{1,1,0,0, 0,0,0,0,4};
        tbl[5]  = '{1,1,0,0, 0,1,0,1,5};
        tbl[6]  = '{1,1,0,0, 1,0,0,1,5};
        tbl[7]  = '{1,1,0,0, 1,0,0,1,5};
        tbl[8]  = '{1,1,0,0, 0,0,0,1,5};
        tbl[9]  = '{1,1,0,0, 0,0,0,1,5};
        tbl[10] = '{1,1,0,0, 0,1,0,1,5};
        tbl[11] = '{1,1,1,1, 1,0,1,1,5};
        tbl[12] = '{1,1,0,0, 1,0,0,1,5};

        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].v, int'(tbl[i].d));
            check($sformatf("table[%0d]", i), dut_out(),
                  {tbl[i].ck, tbl[i].tk, tbl[i].er, tbl[i].rd, tbl[i].cd});
        end

        // Stop request mid-period: period completes, then STOP, then restart.
        cyc("stop_rst", 0, 0, 0, 0);
        cyc("stop_go", 1, 1, 0, 0);
        cyc("stop_c0", 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("stop_drain", 1, 0, 0, 0);
        check("stop_tick", {3'b0, tick, 8'd0}, {3'b0, 1'b1, 8'd0});
        for (int i = 0; i < 4; i++) cyc("stop_idle", 1, 0, 0, 0);
        check("stop_state", {clkout, tick, div_ready, 9'd0}, {3'b001, 9'd0});
        for (int i = 0; i < 8; i++) cyc("stop_restart", 1, 1, 0, 0);

        // Hold valid during PEND: 6 accepted first, 7 only after ready returns.
        cyc("pend_rst", 0, 0, 0, 0);
        cyc("pend_go", 1, 1, 0, 0);
        cyc("pend_6", 1, 1, 1, 6);
        seen6 = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 24 && !done; i++) begin
            cyc("pend_7", 1, 1, 1, 7);
            if (cur_div == 8'd6) seen6 = 1'b1;
            if (cur_div == 8'd7) done = 1'b1;
        end
        check("pend_order", {3'b0, seen6, cur_div}, {3'b0, 1'b1, 8'd7});
        for (int i = 0; i < 8; i++) cyc("pend_run7", 1, 1, 0, 0);

        // Reset while PEND: pending divisor must be discarded.
        cyc("prst_go", 1, 1, 1, 9);
        check("prst_pend", {3'b0, div_ready, 8'd0}, {4'b0, 8'd0});
        cyc("prst_rst", 0, 1, 0, 0);
        check("prst_vals", dut_out(), {4'b0001, 8'd4});
        for (int i = 0; i < 14; i++) cyc("prst_after", 1, 1, 0, 0);
        check("prst_div", {4'b0, cur_div}, {4'b0, 8'd4});

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, v;
            int d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) == 0);
            d = $urandom_range(0, 9);
            cyc("rand", r, e, v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
